// File: rtl/reg_file_dump_reader.sv
// Register file with two combinational bypassed read ports and a handshaked
// dump engine that streams every entry (address + snapshot data) to a trace consumer.
module reg_file_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              dump_done
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // Shared by datapath reads and dump capture: r0 is zero, a same-cycle write wins.
  function automatic logic [DATA_W-1:0] capture(input logic [ADDR_W-1:0] idx);
    if (idx == '0) return '0;
    if (wr_en && (wr_addr == idx)) return wr_data;
    return regs[idx];
  endfunction

  always_comb rd_data_a = capture(rd_addr_a);
  always_comb rd_data_b = capture(rd_addr_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SEND;
          addr_d  = '0;
          data_d  = capture('0);
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (valid_q && dump_ready) begin
          if (addr_q == LAST_IDX) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            addr_d = addr_q + 1'b1;
            data_d = capture(addr_q + 1'b1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Dump engine register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_last  = (addr_q == LAST_IDX);
  assign dump_busy  = (state_q != IDLE);
  assign dump_done  = (state_q == DONE);

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Randomized and directed bench for reg_file_dump_reader against a behavioural
// model of the register contents and the dump stream.
module tb_reg_file_dump_reader;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 2**AW;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] rd_data_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_b;
  logic          dump_start;
  logic          dump_busy;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          dump_done;

  reg_file_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_last(dump_last), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  int            total = 0;
  int            bad   = 0;
  int            n_done = 0;
  beat_t         beats[$];
  logic [DW-1:0] model [NREG];
  bit            m_sending;
  bit            m_done_now;
  int            m_idx;
  logic [DW-1:0] m_snap;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int idx);
    if (idx == 0) return '0;
    if (wr_en && (int'(wr_addr) == idx)) return wr_data;
    return model[idx];
  endfunction

  // Compare everything visible against the model, away from the clock edge.
  task automatic check_all();
    check_eq("rd_a", rd_data_a, exp_rd(int'(rd_addr_a)));
    check_eq("rd_b", rd_data_b, exp_rd(int'(rd_addr_b)));
    check_eq("valid", 32'(dump_valid), 32'(m_sending));
    check_eq("busy", 32'(dump_busy), 32'(m_sending | m_done_now));
    check_eq("done", 32'(dump_done), 32'(m_done_now));
    if (m_sending) begin
      check_eq("daddr", 32'(dump_addr), 32'(m_idx));
      check_eq("ddata", dump_data, m_snap);
      check_eq("dlast", 32'(dump_last), 32'(m_idx == NREG - 1));
    end else if (!m_done_now) begin
      check_eq("idle_addr", 32'(dump_addr), 32'd0);
    end
    if (dump_valid && dump_ready) beats.push_back('{a: 32'(dump_addr), d: dump_data});
    if (dump_done) n_done++;
  endtask

  // Advance the model across one rising edge using the inputs held over it.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
      m_sending = 0; m_done_now = 0; m_idx = 0; m_snap = '0;
    end else begin
      if (m_done_now) begin
        m_done_now = 0;
        m_idx = 0;
      end else if (m_sending) begin
        if (dump_ready) begin
          if (m_idx == NREG - 1) begin
            m_sending = 0;
            m_done_now = 1;
          end else begin
            m_idx++;
            m_snap = exp_rd(m_idx);
          end
        end
      end else if (dump_start) begin
        m_sending = 1;
        m_idx = 0;
        m_snap = exp_rd(0);
      end
      if (wr_en && wr_addr != '0) model[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    tick();
  endtask

  task automatic run_until_done(input string tag);
    int d0;
    d0 = n_done;
    for (int i = 0; i < 400 && n_done == d0; i++) step();
    check_eq(tag, 32'(n_done - d0), 32'd1);
  endtask

  task automatic verify_seq(input string tag);
    check_eq({tag, "_nbeats"}, 32'(beats.size()), 32'(NREG));
    for (int i = 0; i < beats.size() && i < NREG; i++)
      check_eq({tag, "_order"}, beats[i].a, 32'(i));
  endtask

  logic [3:0] pat;
  bit         wrote;
  int         d0;

  initial begin
    reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; dump_start = 0; dump_ready = 0;
    for (int i = 0; i < NREG; i++) model[i] = 32'hFFFF_FFFF;
    m_sending = 0; m_done_now = 0; m_idx = 0; m_snap = '0;
    @(posedge clk); #1;
    tick();
    step();
    reset = 0;

    // Reset state on every index, then r0 stays zero even under a write.
    for (int i = 0; i < NREG; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(NREG - 1 - i);
      @(negedge clk);
      check_eq("rst_a", rd_data_a, 32'd0);
      check_eq("rst_b", rd_data_b, 32'd0);
      check_all();
      tick();
    end
    wr_en = 1; wr_addr = '0; wr_data = 32'hDEADBEEF; rd_addr_a = '0;
    step();
    wr_en = 0;
    step();
    check_eq("r0_hard", rd_data_a, 32'd0);

    // Write-through bypass and storage read-back.
    wr_en = 1; wr_addr = 5; wr_data = 32'h12345678; rd_addr_a = 5;
    @(negedge clk);
    check_eq("bypass", rd_data_a, 32'h12345678);
    check_all();
    tick();
    wr_en = 0;
    @(negedge clk);
    check_eq("stored", rd_data_a, 32'h12345678);
    check_all();
    tick();

    // Load r[i] = i*0x01010101 and dump with ready held high.
    for (int i = 1; i < NREG; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = 32'(i) * 32'h01010101;
      rd_addr_a = AW'($urandom_range(NREG - 1)); rd_addr_b = AW'(i);
      step();
    end
    wr_en = 0;
    beats.delete();
    dump_start = 1; dump_ready = 1;
    step();
    dump_start = 0;
    run_until_done("full_done");
    step();
    verify_seq("full");
    for (int i = 0; i < beats.size() && i < NREG; i++)
      check_eq("full_data", beats[i].d, 32'(i) * 32'h01010101);

    // Stalling consumer with a write to r3 while beat 3 is held.
    beats.delete();
    pat = 4'b1001; wrote = 0;
    dump_start = 1; dump_ready = 0;
    step();
    dump_start = 0;
    d0 = n_done;
    for (int k = 0; k < 400 && n_done == d0; k++) begin
      dump_ready = pat[k % 4];
      if (!wrote && dump_valid && dump_addr == 3 && !dump_ready) begin
        wr_en = 1; wr_addr = 3; wr_data = 32'hAAAA5555; wrote = 1;
      end else begin
        wr_en = 0;
      end
      step();
    end
    wr_en = 0;
    check_eq("stall_done", 32'(n_done - d0), 32'd1);
    check_eq("stall_wrote", 32'(wrote), 32'd1);
    verify_seq("stall");
    if (beats.size() > 3) check_eq("snap_r3", beats[3].d, 32'h03030303);
    rd_addr_a = 3;
    step();
    check_eq("r3_new", rd_data_a, 32'hAAAA5555);

    // Reset while beat 10 is stalled aborts the dump without a done pulse.
    dump_start = 1; dump_ready = 1;
    step();
    dump_start = 0;
    for (int k = 0; k < 50 && !(dump_valid && dump_addr == 10); k++) step();
    check_eq("reach10", 32'(dump_addr), 32'd10);
    dump_ready = 0;
    step();
    d0 = n_done;
    reset = 1;
    step();
    reset = 0; rd_addr_a = 10;
    @(negedge clk);
    check_eq("abort_valid", 32'(dump_valid), 32'd0);
    check_eq("abort_busy", 32'(dump_busy), 32'd0);
    check_eq("abort_r10", rd_data_a, 32'd0);
    check_all();
    tick();
    check_eq("abort_nodone", 32'(n_done), 32'(d0));
    dump_start = 1;
    step();
    dump_start = 0;
    @(negedge clk);
    check_eq("restart_addr", 32'(dump_addr), 32'd0);
    check_eq("restart_valid", 32'(dump_valid), 32'd1);
    check_all();
    tick();
    dump_ready = 1;
    run_until_done("restart_done");

    // dump_start pulsed mid-dump is ignored.
    beats.delete();
    dump_start = 1; dump_ready = 1;
    step();
    dump_start = 0;
    for (int k = 0; k < 50 && !(dump_valid && dump_addr == 7); k++) step();
    dump_start = 1;
    step();
    dump_start = 0;
    d0 = n_done;
    run_until_done("midstart_done");
    for (int k = 0; k < 4; k++) step();
    check_eq("midstart_once", 32'(n_done - d0), 32'd1);
    verify_seq("midstart");

    // Random traffic: writes, reads, dumps, stalls and occasional reset.
    for (int k = 0; k < 1500; k++) begin
      reset      = ($urandom_range(199) == 0);
      wr_en      = $urandom_range(1);
      wr_addr    = AW'($urandom);
      wr_data    = $urandom;
      rd_addr_a  = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom);
      rd_addr_b  = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom);
      dump_start = ($urandom_range(7) == 0);
      dump_ready = ($urandom_range(3) != 0);
      step();
    end
    reset = 0; wr_en = 0; dump_start = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_dump_reader.md
Name: reg_file_dump_reader

Overview:
- Register file of 2**ADDR_W entries × DATA_W bits for the Phase2 datapath.
- Write side:
  - one write port with synchronous reset to zero;
  - write enable held low means the entry keeps its value.
- Read side:
  - two combinational read ports for the datapath;
  - one handshaked dump engine that streams every entry out (address + data) to a debug/trace consumer.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, data width of each entry.
- ADDR_W, 5, address width; entry count NREG = 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write index
- wr_data  input  DATA_W  write data
- rd_addr_a  input  ADDR_W  read port A index
- rd_data_a  output  DATA_W  read port A data (combinational)
- rd_addr_b  input  ADDR_W  read port B index
- rd_data_b  output  DATA_W  read port B data (combinational)
- dump_start  input  1  request full dump (sampled in IDLE only)
- dump_busy  output  1  dump engine not IDLE
- dump_valid  output  1  dump beat valid
- dump_ready  input  1  consumer accepts beat
- dump_addr  output  ADDR_W  index of current beat
- dump_data  output  DATA_W  captured data of current beat
- dump_last  output  1  current beat is index NREG-1
- dump_done  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset:
  - all entries become 0;
  - FSM goes to IDLE;
  - dump_valid, dump_last, dump_done, dump_busy = 0;
  - dump_addr = 0, dump_data = 0.
  - Reset overrides a write or dump_start in the same cycle.
- Write:
  - at posedge with wr_en=1 and wr_addr≠0, entry[wr_addr] <= wr_data;
  - writes to index 0 are ignored.
- Read ports A/B, combinational:
  - rd_addr=0 gives 0;
  - otherwise, if wr_en=1 and wr_addr==rd_addr, the port returns wr_data (write-through bypass);
  - otherwise the port returns entry[rd_addr].
- The dump capture path uses the same bypassed read function, called capture(idx).
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - dump_start=1 → SEND, dump_addr<=0, dump_data<=capture(0), dump_valid<=1.
  - Latency: valid is high the cycle after dump_start.
- SEND:
  - outputs are held stable while dump_valid=1 and dump_ready=0;
  - dump_data does not track later writes to that entry (snapshot taken at capture);
  - dump_last = (dump_addr == NREG-1), combinational from dump_addr.
  - Transfer occurs when dump_valid & dump_ready.
  - Transfer with dump_addr<NREG-1: dump_addr<=dump_addr+1, dump_data<=capture(dump_addr+1), dump_valid stays 1. Throughput is one beat per cycle.
  - Transfer with dump_addr==NREG-1: dump_valid<=0 → DONE.
- DONE:
  - dump_done=1 for exactly one cycle → IDLE;
  - dump_addr returns to 0.
- dump_busy = 1 in SEND and DONE.
- dump_start is ignored while busy; it is a level input, so if held high in IDLE after DONE, a new dump starts.
- Writes and datapath reads proceed normally during a dump; the dump never stalls the datapath.
- Reset mid-dump aborts immediately: valid=0, no dump_done pulse.
- dump_addr increments without wrapping; the engine leaves SEND at NREG-1.

Test Plan:
- Reset, then read all indices on A and B → all 0; write 0xDEADBEEF to r0 → rd_data_a(r0)=0.
- Write r5=0x12345678 with rd_addr_a=5 in the same cycle → rd_data_a=0x12345678 combinationally (bypass); the next cycle it still reads 0x12345678 from storage.
- Load r[i]=i*0x01010101 (r0=0), pulse dump_start, hold dump_ready=1 → 32 consecutive beats:
  - addr 0..31 with matching data;
  - dump_last only on addr 31;
  - dump_done pulses one cycle after beat 31;
  - dump_busy low the following cycle.
- Dump with dump_ready toggling 1,0,0,1 pattern; at addr 3, while stalled, write r3=0xAAAA5555 → beat 3 still presents the old value; no beat is lost or duplicated; total 32 transfers.
- Assert reset while dump_addr=10 is stalled → next cycle dump_valid=0, dump_busy=0, r10=0, no dump_done; a new dump_start then begins at addr 0.
- Pulse dump_start mid-dump at addr 7 → ignored; the sequence continues 8,9,…; exactly one dump_done.
